// File: rtl/pcap_dma_buffer.sv
// Capture-word FIFO between pcap_core and a DMA engine: blocks of BLOCK_WORDS, tail flush, irq.
// Optional PCAP_DMA_STATS_EN adds blocks_o/words_o counters.
module pcap_dma_buffer #(
  parameter int unsigned AW          = 10,
  parameter int unsigned BLOCK_WORDS = 256,
  parameter int unsigned FULL_MARGIN = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [31:0]   pcap_dat_i,
  input  logic          pcap_dat_valid_i,
  input  logic          pcap_done_i,
  input  logic          pcap_actv_i,
  output logic          dma_full_o,
  output logic          dma_req_o,
  output logic [AW:0]   dma_len_o,
  input  logic          dma_ack_i,
  output logic [31:0]   dma_dat_o,
  output logic          dma_valid_o,
  input  logic          dma_ready_i,
  output logic          irq_o,
  output logic          overflow_o,
`ifdef PCAP_DMA_STATS_EN
  output logic [31:0]   blocks_o,
  output logic [31:0]   words_o,
`endif
  output logic [AW:0]   fill_o
);

  localparam int unsigned DEPTH   = 2 ** AW;
  localparam logic [AW:0] DepthC  = (AW+1)'(DEPTH);
  localparam logic [AW:0] BlockC  = (AW+1)'(BLOCK_WORDS);
  localparam logic [AW:0] FullThr = (AW+1)'(DEPTH - FULL_MARGIN);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StDone} state_e;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fill_q, fill_d;
  logic [AW:0]   len_q, remain_q;
  logic          full_q, ovf_q, actv_q, done_q, last_q, req_q, irq_q;
  logic          wr, rd, actv_rise;
  state_e        state_q;

  assign dma_valid_o = (state_q == StXfer) && (fill_q != '0) && (remain_q != '0);
  assign rd          = dma_valid_o && dma_ready_i;
  // A full FIFO still accepts a word when a read frees a slot in the same cycle.
  assign wr          = pcap_dat_valid_i && ((fill_q != DepthC) || rd);
  assign actv_rise   = pcap_actv_i && !actv_q;

  always_comb begin
    fill_d = fill_q + (AW+1)'(wr) - (AW+1)'(rd);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i && wr) begin
      mem_q[wr_ptr_q] <= pcap_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      actv_q   <= 1'b0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q <= fill_d;
      full_q <= (fill_d >= FullThr);
      actv_q <= pcap_actv_i;
      if (actv_rise) ovf_q <= 1'b0;
      if (pcap_dat_valid_i && !wr) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= StIdle;
      done_q   <= 1'b0;
      last_q   <= 1'b0;
      req_q    <= 1'b0;
      irq_q    <= 1'b0;
      len_q    <= '0;
      remain_q <= '0;
    end else begin
      irq_q <= 1'b0;
      if (actv_rise) done_q <= 1'b0;
      if (pcap_done_i) done_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (fill_q >= BlockC) begin
            state_q <= StReq;
            req_q   <= 1'b1;
            len_q   <= BlockC;
            last_q  <= 1'b0;
          end else if (done_q && (fill_q != '0)) begin
            // Tail block: length frozen here, fill cannot shrink before XFER.
            state_q <= StReq;
            req_q   <= 1'b1;
            len_q   <= fill_q;
            last_q  <= 1'b1;
          end else if (done_q) begin
            state_q <= StDone;
            irq_q   <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StReq: begin
          if (dma_ack_i) begin
            req_q    <= 1'b0;
            remain_q <= len_q;
            state_q  <= StXfer;
          end
        end
        StXfer: begin
          if (rd) begin
            remain_q <= remain_q - (AW+1)'(1);
            if (remain_q == (AW+1)'(1)) begin
              if (last_q) begin
                state_q <= StDone;
                irq_q   <= 1'b1;
                done_q  <= 1'b0;
              end else begin
                state_q <= StIdle;
              end
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PCAP_DMA_STATS_EN
  logic [31:0] blocks_q, words_q;
  logic        blk_end;

  assign blk_end = (state_q == StXfer) && rd && (remain_q == (AW+1)'(1));

  always_ff @(posedge clk_i) begin
    if (!reset_i || actv_rise) begin
      blocks_q <= '0;
      words_q  <= '0;
    end else begin
      if (rd && (words_q != 32'hFFFF_FFFF)) words_q <= words_q + 32'd1;
      if (blk_end && (blocks_q != 32'hFFFF_FFFF)) blocks_q <= blocks_q + 32'd1;
    end
  end

  assign blocks_o = blocks_q;
  assign words_o  = words_q;
`endif

  assign dma_dat_o  = dma_valid_o ? mem_q[rd_ptr_q] : 32'd0;
  assign dma_full_o = full_q;
  assign dma_req_o  = req_q;
  assign dma_len_o  = len_q;
  assign irq_o      = irq_q;
  assign overflow_o = ovf_q;
  assign fill_o     = fill_q;

endmodule

// File: tb/tb_pcap_dma_buffer.sv
// Bench for pcap_dma_buffer: directed phases with $urandom data/handshakes, queue-based FIFO model.
module tb_pcap_dma_buffer;

  localparam int AW     = 10;
  localparam int DEPTH  = 1024;
  localparam int BW     = 256;
  localparam int MARGIN = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   dat;
  logic          dvalid, done, actv, ack, ready;
  logic          dma_full_o, dma_req_o, dma_valid_o, irq_o, overflow_o;
  logic [AW:0]   dma_len_o, fill_o;
  logic [31:0]   dma_dat_o;
`ifdef PCAP_DMA_STATS_EN
  logic [31:0]   blocks, words;
`endif

  always #5 clk = ~clk;

  pcap_dma_buffer #(.AW(AW), .BLOCK_WORDS(BW), .FULL_MARGIN(MARGIN)) dut (
    .clk_i            (clk),
    .reset_i          (reset_n),
    .pcap_dat_i       (dat),
    .pcap_dat_valid_i (dvalid),
    .pcap_done_i      (done),
    .pcap_actv_i      (actv),
    .dma_full_o       (dma_full_o),
    .dma_req_o        (dma_req_o),
    .dma_len_o        (dma_len_o),
    .dma_ack_i        (ack),
    .dma_dat_o        (dma_dat_o),
    .dma_valid_o      (dma_valid_o),
    .dma_ready_i      (ready),
    .irq_o            (irq_o),
    .overflow_o       (overflow_o),
`ifdef PCAP_DMA_STATS_EN
    .blocks_o         (blocks),
    .words_o          (words),
`endif
    .fill_o           (fill_o)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          lens[$];
  bit          ovf_m, actv_prev, have_blk, stall_pend;
  int          irq_cnt, req_cnt, blk_cnt, cur_len, seq;
  int          req0, irq0, total;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ready(input int mode);
    if (mode == 0) ready = 1'b1;
    else if (mode == 1) ready = ~ready;
    else ready = 1'($urandom_range(0, 1));
  endtask

  // One clock: entered and left just after a falling edge, inputs already driven.
  task automatic cycle();
    bit rd;
    #1;
    rd = dma_valid_o && ready;
    if (dma_valid_o) begin
      check("valid_has_data", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("dat", dma_dat_o, exp_q[0]);
    end
    if (dma_req_o && ack) begin
      if (have_blk) check("blk_words", blk_cnt, cur_len);
      check("req_len", dma_len_o, (exp_q.size() >= BW) ? BW : exp_q.size());
      cur_len  = int'(dma_len_o);
      have_blk = 1'b1;
      blk_cnt  = 0;
      req_cnt++;
      lens.push_back(cur_len);
    end
    if (rd) blk_cnt++;
    stall_pend = dma_valid_o && !ready;
    if (actv && !actv_prev) ovf_m = 1'b0;
    actv_prev = actv;
    if (rd) void'(exp_q.pop_front());
    if (dvalid) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(dat);
      else ovf_m = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("fill", fill_o, exp_q.size());
    check("full", dma_full_o, exp_q.size() >= DEPTH - MARGIN);
    check("overflow", overflow_o, ovf_m);
    if (stall_pend) check("stall_valid", dma_valid_o, 1);
    if (irq_o) begin
      irq_cnt++;
      check("irq_fill", fill_o, 0);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    dvalid  = 1'b0;
    done    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    ovf_m = 1'b0; actv_prev = 1'b0; have_blk = 1'b0; stall_pend = 1'b0;
    check("rst_fill", fill_o, 0);
    check("rst_req", dma_req_o, 0);
    check("rst_len", dma_len_o, 0);
    check("rst_valid", dma_valid_o, 0);
    check("rst_dat", dma_dat_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_full", dma_full_o, 0);
  endtask

  task automatic push_words(input int n, input bit rnd, input int gap_pct, input int mode);
    for (int i = 0; i < n; i++) begin
      dvalid = 1'b1;
      dat    = rnd ? $urandom : 32'(seq);
      seq++;
      set_ready(mode);
      cycle();
      if ($urandom_range(0, 99) < gap_pct) begin
        dvalid = 1'b0;
        set_ready(mode);
        cycle();
      end
    end
    dvalid = 1'b0;
  endtask

  task automatic drain(input int budget, input int mode);
    int n = 0;
    dvalid = 1'b0;
    while ((exp_q.size() != 0 || dma_req_o || dma_valid_o) && n < budget) begin
      set_ready(mode);
      cycle();
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      set_ready(mode);
      cycle();
    end
    check("drain_empty", exp_q.size(), 0);
    if (have_blk) check("blk_words_end", blk_cnt, cur_len);
    have_blk = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    cycle();
    done = 1'b0;
  endtask

  task automatic new_phase();
    actv = 1'b0;
    cycle();
    actv = 1'b1;
    cycle();
    req0 = req_cnt;
    irq0 = irq_cnt;
    lens.delete();
    seq = 0;
  endtask

  initial begin
    reset_n = 1'b0; dat = '0; dvalid = 1'b0; done = 1'b0; actv = 1'b0;
    ack = 1'b1; ready = 1'b1;
    irq_cnt = 0; req_cnt = 0; blk_cnt = 0; cur_len = 0; seq = 0;
    @(negedge clk);
    do_reset();

    // Two full blocks, streaming reader.
    new_phase();
    push_words(512, 1'b0, 0, 0);
    drain(3000, 0);
    check("t1_reqs", req_cnt - req0, 2);
    check("t1_len0", lens[0], BW);
    check("t1_len1", lens[1], BW);
    check("t1_irq", irq_cnt - irq0, 0);

    // Partial flush on done.
    new_phase();
    push_words(100, 1'b1, 0, 0);
    pulse_done();
    drain(3000, 0);
    check("t2_reqs", req_cnt - req0, 1);
    check("t2_len", lens[0], 100);
    check("t2_irq", irq_cnt - irq0, 1);

    // Back-pressure and overflow with the DMA engine withholding ack.
    new_phase();
    ack = 1'b0;
    push_words(1030, 1'b0, 0, 0);
    check("t3_fill", fill_o, DEPTH);
    check("t3_ovf", overflow_o, 1);
    check("t3_full", dma_full_o, 1);
    ack = 1'b1;
    drain(5000, 0);
    check("t3_reqs", req_cnt - req0, 4);
    check("t3_irq", irq_cnt - irq0, 0);
    check("t3_ovf_sticky", overflow_o, 1);
    new_phase();
    check("t3_ovf_clr", overflow_o, 0);

    // Reader stalls on alternate cycles.
    new_phase();
    ready = 1'b0;
    push_words(256, 1'b1, 0, 1);
    drain(3000, 1);
    check("t4_reqs", req_cnt - req0, 1);
    check("t4_irq", irq_cnt - irq0, 0);

    // Done arrives while the first block is still transferring.
    new_phase();
    push_words(296, 1'b0, 0, 0);
    check("t5_in_xfer", dma_valid_o, 1);
    pulse_done();
    drain(3000, 0);
    check("t5_reqs", req_cnt - req0, 2);
    check("t5_len0", lens[0], BW);
    check("t5_len1", lens[1], 40);
    check("t5_irq", irq_cnt - irq0, 1);

    // Reset in the middle of a transfer, then a clean capture.
    new_phase();
    push_words(256, 1'b1, 0, 0);
    for (int i = 0; i < 50; i++) cycle();
    check("t6_mid_xfer", dma_valid_o, 1);
    do_reset();
    for (int i = 0; i < 20; i++) cycle();
    check("t6_no_irq", irq_cnt - irq0, 0);
    new_phase();
    push_words(256, 1'b1, 0, 0);
    pulse_done();
    drain(3000, 0);
    check("t6_reqs", req_cnt - req0, 1);
    check("t6_len", lens[0], BW);
    check("t6_irq", irq_cnt - irq0, 1);

    // Random data, random gaps, random reader, then flush.
    new_phase();
    total = $urandom_range(300, 700);
    push_words(total, 1'b1, 30, 2);
    pulse_done();
    drain(8000, 2);
    check("t7_irq", irq_cnt - irq0, 1);
    begin
      int sum = 0;
      foreach (lens[i]) sum += lens[i];
      check("t7_words", sum, total);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pcap_dma_buffer.md
Name: pcap_dma_buffer

Overview:
- Sits directly downstream of pcap_core and consumes its captured word stream (pcap_dat, pcap_dat_valid, pcap_done, pcap_actv).
- Buffers the words in an on-chip FIFO and drives the back-pressure flag into pcap_core's dma_full_i.
- Groups the words into fixed-length blocks and hands each block to the DMA engine over a request/acknowledge and valid/ready interface.
- Flushes any partial last block when capture completes, then raises a completion interrupt.

Parameters:
- AW, 10: FIFO address width. DEPTH = 2**AW words.
- BLOCK_WORDS, 256: words per full DMA block, 1..DEPTH.
- FULL_MARGIN, 16: dma_full_o asserts when fill >= DEPTH-FULL_MARGIN.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-low reset.
- pcap_dat_i  in  32  captured word from pcap_core.
- pcap_dat_valid_i  in  1  word strobe, one word per cycle when high.
- pcap_done_i  in  1  single-cycle pulse: capture finished.
- pcap_actv_i  in  1  capture active level.
- dma_full_o  out  1  back-pressure to pcap_core dma_full_i.
- dma_req_o  out  1  block request to the DMA engine.
- dma_len_o  out  AW+1  word count of the requested block.
- dma_ack_i  in  1  DMA engine accepts the request.
- dma_dat_o  out  32  block data.
- dma_valid_o  out  1  dma_dat_o valid.
- dma_ready_i  in  1  DMA engine takes the word.
- irq_o  out  1  single-cycle pulse: last block drained.
- overflow_o  out  1  sticky flag: a word was lost.
- fill_o  out  AW+1  current FIFO occupancy.

Behaviour:
- Reset (reset_i==0 at a clock edge):
  - FIFO pointers cleared and fill=0.
  - State goes to IDLE and the done latch clears.
  - All outputs return to 0.
  - A reset mid-block discards all buffered data, with no irq.
- FIFO write:
  - pcap_dat_valid_i && fill<DEPTH writes the word.
  - pcap_dat_valid_i && fill==DEPTH drops the word and sets overflow_o.
  - overflow_o clears only on reset or on the rising edge of pcap_actv_i.
- FIFO read:
  - A read happens only on dma_valid_o && dma_ready_i.
  - The output register is first-word-fall-through: dma_dat_o is valid in the same cycle dma_valid_o is high.
- fill arithmetic:
  - fill = fill + wr - rd, width AW+1.
  - A simultaneous write and read leaves fill unchanged.
  - Writing at fill==DEPTH while reading in the same cycle is accepted (the read frees the slot first).
- dma_full_o: registered; high when next-fill >= DEPTH-FULL_MARGIN.
- Done latch:
  - Set by pcap_done_i.
  - Cleared on entering DONE, or on a rising edge of pcap_actv_i.
- State machine:
  - IDLE -> REQ when fill>=BLOCK_WORDS. dma_len_o=BLOCK_WORDS.
  - IDLE -> REQ when done latch && fill>0. dma_len_o=fill, frozen at REQ entry; this is the last block.
  - IDLE -> DONE when done latch && fill==0.
  - REQ: dma_req_o=1 and dma_len_o held stable until dma_ack_i. Then go to XFER and load remain=dma_len_o.
  - XFER: dma_valid_o=1 while fill>0 and remain>0. remain decrements per accepted word. When remain reaches 0, go to IDLE, or to DONE if this was the last block.
  - DONE: irq_o=1 for one cycle, then IDLE.
- dma_valid_o only rises once the requested length is guaranteed available. For full blocks, words written during XFER may be drained within the same block.
- pcap_done_i arriving during REQ/XFER is latched and the flush happens after the current block.
- Latency: a write at cycle N raises fill_o at N+1, and dma_full_o at N+1.

Optional Feature:
- Macro: PCAP_DMA_STATS_EN.
- When defined:
  - Adds outputs blocks_o[31:0] and words_o[31:0].
  - Both count completed DMA blocks and transferred words since the last rising edge of pcap_actv_i.
  - Both clear on reset and saturate at 32'hFFFF_FFFF.
- When undefined: the ports and counters are absent and the core behaviour is identical.

Test Plan:
- Full blocks: 512 consecutive words 0..511 with BLOCK_WORDS=256 and dma_ack_i immediate, dma_ready_i=1.
  - Two requests, each with dma_len_o=256.
  - Data 0..511 in order and no irq.
- Partial flush: 100 words then pcap_done_i.
  - One request with dma_len_o=100.
  - 100 words out, then irq_o pulses once, with fill_o=0.
- Back-pressure and overflow: dma_ack_i held 0 while 1030 words are written, AW=10.
  - dma_full_o rises when fill reaches 1008.
  - fill_o saturates at 1024 and overflow_o=1.
  - After ack and drain, the data is 0..1023.
- Stalled reader: 256 words with dma_ready_i toggling 1/0.
  - No duplicated or skipped words.
  - dma_dat_o held stable while ready=0.
- Done mid-transfer: pcap_done_i pulses during XFER of block 1 with 40 words residual.
  - Block 1 completes with 256 words, then a second request with len=40, then irq.
- Reset mid-XFER: reset_i=0 for one cycle.
  - All outputs 0, fill_o=0, no irq.
  - The next capture starts clean.
